// File: rtl/arb4_pkg.sv
// Shared constants, state encoding and round-robin search for the 4-way arbiter.
package arb4_pkg;

    localparam int unsigned NREQ = 4;
    localparam int unsigned ID_W = 2;

    typedef logic [0:0] state_t;

    localparam state_t IDLE  = 1'b0;
    localparam state_t GRANT = 1'b1;

    // First set request bit searching upward from ptr, wrapping modulo NREQ.
    function automatic logic [ID_W-1:0] rr_pick(input logic [NREQ-1:0] req,
                                                 input logic [ID_W-1:0] ptr);
        logic [ID_W-1:0] idx;
        logic [ID_W-1:0] pick;
        logic            found;
        pick  = ptr;
        found = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = ptr + ID_W'(i);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/gnt_dec2_4.sv
// Enabled 2-to-4 one-hot decoder driving the grant lines.
module gnt_dec2_4 (
    input  logic E,
    input  logic S1,
    input  logic S0,
    output logic O0,
    output logic O1,
    output logic O2,
    output logic O3
);

    // One output high only when enabled.
    assign O0 = E & ~S1 & ~S0;
    assign O1 = E & ~S1 &  S0;
    assign O2 = E &  S1 & ~S0;
    assign O3 = E &  S1 &  S0;

endmodule

// File: rtl/arb4_rr_ctrl.sv
// 4-requester round-robin arbiter with a two-state IDLE/GRANT controller.
// Optional hold-time limit and TIMEOUT pulse: define ARB4_TIMEOUT_EN.
module arb4_rr_ctrl
    import arb4_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 15,
    parameter int unsigned CNT_W    = 8
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            E,
    input  logic [NREQ-1:0] REQ,
    input  logic            DONE,
    output logic [NREQ-1:0] GNT,
    output logic [ID_W-1:0] GNT_ID,
    output logic            BUSY,
    output logic            TIMEOUT
);

    // Reject hold limits the counter cannot represent.
    if (MAX_HOLD < 1 || MAX_HOLD > 255 || (64'(1) << CNT_W) <= 64'(MAX_HOLD)) begin : g_bad_cfg
        $error("arb4_rr_ctrl: MAX_HOLD must be 1..255 and below 2**CNT_W");
    end

    state_t          state_q, state_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W-1:0] gnt_id_q, gnt_id_d;
    logic [ID_W-1:0] pick_c;
    logic            hold_ok_c;
    logic            grant_en_c;

`ifdef ARB4_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
    logic             expire_c;

    // Hold limit reached on this edge: count including the current cycle hits MAX_HOLD.
    assign expire_c = (state_q == GRANT) && (cnt_q == CNT_W'(MAX_HOLD - 1));
`endif

    // Candidate grantee from the rotating priority pointer.
    assign pick_c    = rr_pick(REQ, ptr_q);
    assign hold_ok_c = E & REQ[gnt_id_q];

    // Next-state and datapath updates.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gnt_id_d = gnt_id_q;
`ifdef ARB4_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (E && (|REQ)) begin
                    state_d  = GRANT;
                    gnt_id_d = pick_c;
                    ptr_d    = pick_c + ID_W'(1);
`ifdef ARB4_TIMEOUT_EN
                    cnt_d    = '0;
`endif
                end
            end
            GRANT: begin
`ifdef ARB4_TIMEOUT_EN
                cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
                // DONE wins over a coincident timeout; only a forced release pulses.
                timeout_d = expire_c && !DONE && hold_ok_c;
                if (DONE || !hold_ok_c || expire_c) begin
                    state_d = IDLE;
                end
`else
                if (DONE || !hold_ok_c) begin
                    state_d = IDLE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            gnt_id_q <= '0;
`ifdef ARB4_TIMEOUT_EN
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gnt_id_q <= gnt_id_d;
`ifdef ARB4_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    // Grant drops combinationally with E or an asynchronous reset.
    assign grant_en_c = (state_q == GRANT) & E;

    gnt_dec2_4 u_gnt_dec (
        .E  (grant_en_c),
        .S1 (gnt_id_q[1]),
        .S0 (gnt_id_q[0]),
        .O0 (GNT[0]),
        .O1 (GNT[1]),
        .O2 (GNT[2]),
        .O3 (GNT[3])
    );

    assign GNT_ID = gnt_id_q;
    assign BUSY   = (state_q == GRANT);

`ifdef ARB4_TIMEOUT_EN
    assign TIMEOUT = timeout_q;
`else
    assign TIMEOUT = 1'b0;
`endif

endmodule

// File: tb/tb_arb4_rr_ctrl.sv
// Directed self-checking bench for arb4_rr_ctrl.
module tb_arb4_rr_ctrl;

    logic       CLK;
    logic       RST;
    logic       E;
    logic [3:0] REQ;
    logic       DONE;
    logic [3:0] GNT;
    logic [1:0] GNT_ID;
    logic       BUSY;
    logic       TIMEOUT;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] exp_seq [5];

    arb4_rr_ctrl #(.MAX_HOLD(3), .CNT_W(8)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .E       (E),
        .REQ     (REQ),
        .DONE    (DONE),
        .GNT     (GNT),
        .GNT_ID  (GNT_ID),
        .BUSY    (BUSY),
        .TIMEOUT (TIMEOUT)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if (GNT !== 4'b0000 || BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: GNT=%b BUSY=%b, expected GNT=0000 BUSY=0", GNT, BUSY);
        end
        n_checks++;
        if (GNT_ID !== 2'd0 || TIMEOUT !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_id: GNT_ID=%0d TIMEOUT=%b, expected 0 and 0", GNT_ID, TIMEOUT);
        end
        step();
        n_checks++;
        if (GNT !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_held: GNT=%b expected 0000 while RST=1", GNT);
        end
        RST = 1'b0;
        step();
        n_checks++;
        if (GNT !== 4'b0001 || BUSY !== 1'b1) begin
            n_fail++;
            $display("FAIL first_grant: GNT=%b BUSY=%b, expected GNT=0001 BUSY=1", GNT, BUSY);
        end
    endtask

    task automatic test_round_robin();
        for (int k = 1; k <= 4; k++) begin
            DONE = 1'b1;
            step();
            n_checks++;
            if (GNT !== 4'b0000 || BUSY !== 1'b0) begin
                n_fail++;
                $display("FAIL rr_gap%0d: GNT=%b BUSY=%b, expected 0000 and 0", k, GNT, BUSY);
            end
            n_checks++;
            if (GNT_ID !== 2'(k - 1)) begin
                n_fail++;
                $display("FAIL rr_id_hold%0d: GNT_ID=%0d expected %0d", k, GNT_ID, k - 1);
            end
            DONE = 1'b0;
            step();
            n_checks++;
            if (GNT !== exp_seq[k]) begin
                n_fail++;
                $display("FAIL rr_grant%0d: GNT=%b expected %b", k, GNT, exp_seq[k]);
            end
        end
    endtask

    task automatic test_ignore_requests();
        DONE = 1'b1;
        REQ  = 4'b0000;
        step();
        n_checks++;
        if (BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL ign_release: BUSY=%b expected 0", BUSY);
        end
        DONE = 1'b0;
        REQ  = 4'b0010;
        step();
        n_checks++;
        if (GNT !== 4'b0010) begin
            n_fail++;
            $display("FAIL ign_grant1: GNT=%b expected 0010", GNT);
        end
        REQ = 4'b0011;
        step();
        n_checks++;
        if (GNT !== 4'b0010) begin
            n_fail++;
            $display("FAIL ign_no_switch: GNT=%b expected 0010", GNT);
        end
        DONE = 1'b1;
        step();
        n_checks++;
        if (GNT !== 4'b0000) begin
            n_fail++;
            $display("FAIL ign_gap: GNT=%b expected 0000", GNT);
        end
        DONE = 1'b0;
        step();
        n_checks++;
        if (GNT !== 4'b0001) begin
            n_fail++;
            $display("FAIL ign_wrap_pick: GNT=%b expected 0001", GNT);
        end
    endtask

    task automatic test_enable_drop();
        DONE = 1'b1;
        REQ  = 4'b0010;
        step();
        DONE = 1'b0;
        step();
        n_checks++;
        if (GNT !== 4'b0010 || GNT_ID !== 2'd1) begin
            n_fail++;
            $display("FAIL en_grant1: GNT=%b GNT_ID=%0d, expected 0010 and 1", GNT, GNT_ID);
        end
        REQ = 4'b1111;
        E   = 1'b0;
        #1;
        n_checks++;
        if (GNT !== 4'b0000 || BUSY !== 1'b1) begin
            n_fail++;
            $display("FAIL en_comb_drop: GNT=%b BUSY=%b, expected 0000 and 1", GNT, BUSY);
        end
        step();
        n_checks++;
        if (BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL en_exit: BUSY=%b expected 0", BUSY);
        end
        step();
        n_checks++;
        if (BUSY !== 1'b0 || GNT !== 4'b0000) begin
            n_fail++;
            $display("FAIL en_idle_hold: GNT=%b BUSY=%b, expected 0000 and 0", GNT, BUSY);
        end
        E = 1'b1;
        step();
        n_checks++;
        if (GNT !== 4'b0100) begin
            n_fail++;
            $display("FAIL en_resume_ptr: GNT=%b expected 0100", GNT);
        end
    endtask

`ifdef ARB4_TIMEOUT_EN
    task automatic test_timeout();
        E = 1'b0;
        step();
        REQ = 4'b0100;
        E   = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            step();
            n_checks++;
            if (GNT !== 4'b0100 || TIMEOUT !== 1'b0) begin
                n_fail++;
                $display("FAIL to_hold%0d: GNT=%b TIMEOUT=%b, expected 0100 and 0", c, GNT, TIMEOUT);
            end
        end
        step();
        n_checks++;
        if (GNT !== 4'b0000 || TIMEOUT !== 1'b1 || BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL to_pulse: GNT=%b TIMEOUT=%b BUSY=%b, expected 0000 1 0", GNT, TIMEOUT, BUSY);
        end
        step();
        n_checks++;
        if (GNT !== 4'b0100 || TIMEOUT !== 1'b0) begin
            n_fail++;
            $display("FAIL to_regrant: GNT=%b TIMEOUT=%b, expected 0100 and 0", GNT, TIMEOUT);
        end
        step();
        step();
        DONE = 1'b1;
        step();
        n_checks++;
        if (TIMEOUT !== 1'b0 || BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL to_done_wins: TIMEOUT=%b BUSY=%b, expected 0 and 0", TIMEOUT, BUSY);
        end
        DONE = 1'b0;
    endtask
`else
    task automatic test_no_timeout();
        for (int c = 0; c < 20; c++) begin
            step();
            n_checks++;
            if (GNT !== 4'b0100 || TIMEOUT !== 1'b0) begin
                n_fail++;
                $display("FAIL nto_hold%0d: GNT=%b TIMEOUT=%b, expected 0100 and 0", c, GNT, TIMEOUT);
            end
        end
    endtask
`endif

    task automatic test_async_reset();
        E = 1'b0;
        step();
        step();
        E   = 1'b1;
        REQ = 4'b1000;
        step();
        n_checks++;
        if (GNT !== 4'b1000) begin
            n_fail++;
            $display("FAIL ar_grant: GNT=%b expected 1000", GNT);
        end
        #3;
        RST = 1'b1;
        #1;
        n_checks++;
        if (GNT !== 4'b0000 || BUSY !== 1'b0 || GNT_ID !== 2'd0 || TIMEOUT !== 1'b0) begin
            n_fail++;
            $display("FAIL ar_async_drop: GNT=%b BUSY=%b GNT_ID=%0d TIMEOUT=%b, expected 0000 0 0 0",
                     GNT, BUSY, GNT_ID, TIMEOUT);
        end
        #1;
        RST = 1'b0;
        REQ = 4'b1111;
        step();
        n_checks++;
        if (GNT !== 4'b0001) begin
            n_fail++;
            $display("FAIL ar_ptr_cleared: GNT=%b expected 0001", GNT);
        end
    endtask

    initial begin
        exp_seq[0] = 4'b0001;
        exp_seq[1] = 4'b0010;
        exp_seq[2] = 4'b0100;
        exp_seq[3] = 4'b1000;
        exp_seq[4] = 4'b0001;
        RST  = 1'b1;
        E    = 1'b1;
        REQ  = 4'b1111;
        DONE = 1'b0;

        test_reset();
        test_round_robin();
        test_ignore_requests();
        test_enable_drop();
`ifdef ARB4_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_async_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
